// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the register file and its bypass muxes.
package riscv_pkg;

  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;

  // Low bit of field 'idx' in a flattened bus of 'field_w'-bit fields.
  function automatic int unsigned sel_lo(input int unsigned idx, input int unsigned field_w);
    return idx * field_w;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port bypass: picks the highest-index legal write whose select
// matches the read select, otherwise passes the stored register value.
module regfile_bypass_mux
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned NUM_WR = 2
) (
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic [NUM_WR-1:0]       wr_legal,
  input  logic [NUM_WR*SEL_W-1:0] wr_sel,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0]        stored,
  output logic [WIDTH-1:0]        data,
  output logic                    hit
);

  // Ascending scan so the last match (highest port index) wins.
  always_comb begin
    data = stored;
    hit  = 1'b0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_legal[w] && (wr_sel[sel_lo(w, SEL_W) +: SEL_W] == rd_sel)) begin
        data = wr_data[sel_lo(w, WIDTH) +: WIDTH];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// busy scoreboard for RAW hazard detection at decode.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic [NUM_RD*SEL_W-1:0] rd_sel,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*SEL_W-1:0] wr_sel,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic                    issue_en,
  input  logic [SEL_W-1:0]        issue_sel,
  output logic [SEL_W:0]          busy_cnt
);

  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(REG_ZERO);
  localparam logic             HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [SEL_W:0]      cnt_next;
  logic [NUM_WR-1:0]   wr_legal;
  logic                issue_legal;
  logic [NUM_RD-1:0]   hit;

  // Legality of each write port and of the issue request.
  always_comb begin
    wr_legal = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_legal[w] = wr_en[w] && !halt && !reset &&
                    !(HAS_ZERO && (wr_sel[sel_lo(w, SEL_W) +: SEL_W] == ZERO_SEL));
    end
    issue_legal = issue_en && !halt && !reset && !(HAS_ZERO && (issue_sel == ZERO_SEL));
  end

  // Next busy vector: writes clear, then a same-cycle issue re-sets; popcount follows.
  always_comb begin
    busy_next = busy;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_legal[w]) busy_next[wr_sel[sel_lo(w, SEL_W) +: SEL_W]] = 1'b0;
    end
    if (issue_legal) busy_next[issue_sel] = 1'b1;
    cnt_next = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_next = cnt_next + (SEL_W+1)'(busy_next[r]);
    end
  end

  // Register array update; ascending port order lets the highest index win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_legal[w]) regs[wr_sel[sel_lo(w, SEL_W) +: SEL_W]] <= wr_data[sel_lo(w, WIDTH) +: WIDTH];
      end
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (!halt) begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] stored;

    assign sel    = rd_sel[i*SEL_W +: SEL_W];
    assign stored = (HAS_ZERO && (sel == ZERO_SEL)) ? '0 : regs[sel];

    regfile_bypass_mux #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .NUM_WR(NUM_WR)
    ) u_mux (
      .rd_sel  (sel),
      .wr_legal(wr_legal),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .stored  (stored),
      .data    (rd_data[i*WIDTH +: WIDTH]),
      .hit     (hit[i])
    );

    // A same-cycle write is forwarded, so it does not count as a hazard.
    assign rd_busy[i] = busy[sel] && !hit[i];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a monitor
// on the falling edge pops and compares them against the DUT.
module tb_regfile_scoreboard;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned SW = 5;

  logic            clk = 1'b0;
  logic            reset, halt, issue_en;
  logic [2*SW-1:0] rd_sel;
  logic [2*W-1:0]  rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*SW-1:0] wr_sel;
  logic [2*W-1:0]  wr_data;
  logic [SW-1:0]   issue_sel;
  logic [SW:0]     busy_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_cnt
    int          port;
    logic [31:0] value;
  } exp_t;

  exp_t q[$];

  regfile_scoreboard #(
    .WIDTH   (W),
    .NUM_REGS(NR),
    .NUM_RD  (2),
    .NUM_WR  (2),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .halt     (halt),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_sel(issue_sel),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic void push(input string n, input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.port = p; e.value = v;
    q.push_back(e);
  endfunction

  // Monitor: outputs are stable mid-cycle, so compare everything queued.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = rd_data[e.port*W +: W];
        1:       act = 32'(rd_busy[e.port]);
        default: act = 32'(busy_cnt);
      endcase
      checks++;
      if (act !== e.value) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.value);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; halt = 1'b0; wr_en = 2'b00; issue_en = 1'b0;
  endtask

  task automatic set_rd(input int s0, input int s1);
    rd_sel = {SW'(s1), SW'(s0)};
  endtask

  task automatic set_wr(input logic [1:0] en, input int s0, input logic [31:0] d0,
                        input int s1, input logic [31:0] d1);
    wr_en = en;
    wr_sel = {SW'(s1), SW'(s0)};
    wr_data = {d1, d0};
  endtask

  initial begin
    // Reset cycle with writes and an issue that must be discarded.
    reset = 1'b1; halt = 1'b0;
    set_rd(3, 6);
    set_wr(2'b11, 3, 32'hAAAA, 4, 32'hBBBB);
    issue_en = 1'b1; issue_sel = SW'(6);
    step();

    idle(); set_rd(3, 6);
    push("rst_data0", 0, 0, 32'h0);
    push("rst_data1", 0, 1, 32'h0);
    push("rst_busy0", 1, 0, 32'h0);
    push("rst_busy1", 1, 1, 32'h0);
    push("rst_cnt",   2, 0, 32'h0);
    step();

    // Dual write to x5: port 1 wins, bypassed the same cycle.
    set_wr(2'b11, 5, 32'h11, 5, 32'h22); set_rd(5, 4);
    push("dual_bypass", 0, 0, 32'h22);
    push("dual_busy",   1, 0, 32'h0);
    push("rst_x4",      0, 1, 32'h0);
    step();
    idle(); set_rd(5, 4);
    push("dual_stored", 0, 0, 32'h22);
    step();

    // Zero register ignores writes and issues.
    set_wr(2'b01, 0, 32'hDEAD, 0, 32'h0);
    issue_en = 1'b1; issue_sel = SW'(0); set_rd(0, 5);
    push("zero_bypass", 0, 0, 32'h0);
    push("zero_busy",   1, 0, 32'h0);
    step();
    idle(); set_rd(0, 5);
    push("zero_after", 0, 0, 32'h0);
    push("zero_busy2", 1, 0, 32'h0);
    push("zero_cnt",   2, 0, 32'h0);
    push("x5_notbusy", 1, 1, 32'h0);
    step();

    // Scoreboard lifecycle on x7.
    issue_en = 1'b1; issue_sel = SW'(7); set_rd(7, 5);
    push("issue_nobusy_yet", 1, 0, 32'h0);
    step();
    idle(); set_rd(7, 5);
    push("life_busy", 1, 0, 32'h1);
    push("life_cnt",  2, 0, 32'h1);
    step();
    set_wr(2'b01, 7, 32'h55, 0, 32'h0); set_rd(7, 5);
    push("life_wr_busy", 1, 0, 32'h0);
    push("life_wr_data", 0, 0, 32'h55);
    push("life_wr_cnt",  2, 0, 32'h1);
    step();
    idle(); set_rd(7, 5);
    push("life_cnt0", 2, 0, 32'h0);
    push("life_data", 0, 0, 32'h55);
    push("life_busy0", 1, 0, 32'h0);
    step();

    // Issue/write collision on x9.
    issue_en = 1'b1; issue_sel = SW'(9); set_rd(0, 9);
    step();
    idle(); set_rd(0, 9);
    push("col_busy_pre", 1, 1, 32'h1);
    push("col_cnt_pre",  2, 0, 32'h1);
    step();
    set_wr(2'b10, 0, 32'h0, 9, 32'h3);
    issue_en = 1'b1; issue_sel = SW'(9); set_rd(0, 9);
    push("col_hit_busy", 1, 1, 32'h0);
    push("col_hit_data", 0, 1, 32'h3);
    step();
    idle(); set_rd(0, 9);
    push("col_data", 0, 1, 32'h3);
    push("col_busy", 1, 1, 32'h1);
    push("col_cnt",  2, 0, 32'h1);
    step();

    // Halt freezes state and disables bypass.
    set_wr(2'b01, 3, 32'h10, 0, 32'h0); set_rd(3, 9);
    step();
    idle(); set_rd(3, 9);
    push("halt_pre", 0, 0, 32'h10);
    step();
    halt = 1'b1;
    set_wr(2'b11, 3, 32'h99, 9, 32'h77);
    issue_en = 1'b1; issue_sel = SW'(4); set_rd(3, 9);
    push("halt_nobypass", 0, 0, 32'h10);
    push("halt_busy9",    1, 1, 32'h1);
    push("halt_cnt",      2, 0, 32'h1);
    step();
    set_rd(3, 4);
    push("halt_hold",  0, 0, 32'h10);
    push("halt_x4",    1, 1, 32'h0);
    push("halt_cnt2",  2, 0, 32'h1);
    step();
    idle(); set_rd(3, 9);
    push("post_x3",   0, 0, 32'h10);
    push("post_x9",   0, 1, 32'h3);
    push("post_cnt",  2, 0, 32'h1);
    step();
    set_rd(4, 9);
    push("post_x4", 1, 0, 32'h0);
    push("post_b9", 1, 1, 32'h1);
    step();

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write, two-read write-back register file.
- Provides NUM_RD read ports and NUM_WR write ports with same-cycle write-to-read bypass, plus a per-register busy scoreboard so decode can detect pending writers (RAW hazards).
- Sits between decode (reads, issue) and write-back (writes) in the pipelined core; halt freezes all architectural state.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers (power of two, >= 2).
- SEL_W, $clog2(NUM_REGS), register select width (localparam, derived).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- halt  in  1  when high, blocks all writes, issues and busy updates.
- rd_sel  in  NUM_RD*SEL_W  read selects; port i = bits [i*SEL_W +: SEL_W].
- rd_data  out  NUM_RD*WIDTH  read data per port, combinational.
- rd_busy  out  NUM_RD  selected register still has an outstanding writer, combinational.
- wr_en  in  NUM_WR  write enables.
- wr_sel  in  NUM_WR*SEL_W  write selects.
- wr_data  in  NUM_WR*WIDTH  write data.
- issue_en  in  1  marks the register at issue_sel as pending.
- issue_sel  in  SEL_W  destination register of the newly issued instruction.
- busy_cnt  out  SEL_W+1  registered count of busy registers.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state:
  - The cycle after reset is sampled: all registers = 0, all busy bits = 0, busy_cnt = 0.
  - reset has priority over halt and over every write or issue.
  - Reset asserted mid-operation discards same-cycle writes and issues.
- Write legality: a write on port w is legal when wr_en[w] && !halt && !reset, and (ZERO_REG == 0 or wr_sel[w] != 0).
  - A legal write updates the register at the next clk edge.
  - When several legal writes target the same register, the highest port index wins.
- Read (combinational, zero latency):
  - rd_data[i] = data of the highest-index legal write with wr_sel == rd_sel[i]; otherwise the stored register value.
  - With ZERO_REG = 1, a read of register 0 returns 0.
  - Bypass is gated by halt: while halted, reads return stored values only.
- Scoreboard: one busy bit per register.
  - A legal issue (issue_en && !halt && !reset, sel nonzero when ZERO_REG = 1) sets busy[issue_sel] at the next edge.
  - A legal write clears busy[wr_sel] at the next edge.
  - Same-cycle issue and write to the same register: the issue wins and the bit ends set, because a new producer supersedes the old one.
  - Writing a non-busy register is legal; the bit stays 0.
- rd_busy[i] = busy[rd_sel[i]] && !(a legal write to rd_sel[i] this cycle).
  - A write in the same cycle is bypassed, so it is not a hazard.
  - A same-cycle issue does not affect rd_busy until the next cycle.
  - Register 0 reads not busy when ZERO_REG = 1.
- busy_cnt: population count of the busy vector, registered. It reflects the busy state after each edge, i.e. the count of the current busy bits.
- halt: registers, busy bits and busy_cnt hold; rd_busy reflects the stored busy bits only.
- Register selects are full-range (NUM_REGS is a power of two), so there are no out-of-range selects.

Decomposition:
- Shared package (riscv_pkg): REG_ZERO index constant; default WIDTH and NUM_REGS; a select-slice helper function for flattened port buses.
- One natural sub-module: regfile_bypass_mux (one per read port). It performs the priority match of rd_sel against all write ports and returns the selected data plus a write-hit flag, which feeds both rd_data and rd_busy.

Test Plan:
- Reset: hold reset 1 cycle with wr_en = 2'b11 and issue_en = 1 -> all reads return 0, rd_busy = 0, busy_cnt = 0; the writes are discarded.
- Dual-write priority: wr0 (x5, 0x11) and wr1 (x5, 0x22) in the same cycle with rd_sel0 = 5 -> rd_data0 = 0x22 that cycle; the next cycle x5 reads 0x22.
- Zero register: write x0 = 0xDEAD and issue x0 -> a read of x0 returns 0, rd_busy = 0, busy_cnt unchanged.
- Scoreboard lifecycle: issue x7 -> next cycle rd_busy = 1 and busy_cnt = 1; write x7 = 0x55 -> that cycle rd_busy = 0 and rd_data = 0x55; the following cycle busy_cnt = 0.
- Issue/write collision: x9 busy; issue x9 and write x9 = 0x3 in the same cycle -> next cycle x9 = 0x3, still busy, busy_cnt unchanged.
- Halt: x3 = 0x10; assert halt, then write x3 = 0x99 and issue x4 -> a read of x3 returns 0x10 during and after halt, x4 is not busy, busy_cnt is unchanged.
